ir_scan_scheduler: RTL and testbench

- Sequences the single shared ADC and the single shared adc_lut instance across three IR distance sensors: front, diagonal-left and diagonal-right.
- For each sensor in turn, per scan:
  - triggers 2^AVG_LOG2 ADC conversions;
  - averages them;
  - presents the average to the LUT;
  - registers the returned distance.
- Sits between the ADC interface and the PID wall-follower, which consumes the per-sensor distances and the scan_done strobe.

---
 rtl/ir_scan_scheduler.sv | 175 +++++++++++++++++
 tb/tb_ir_scan_scheduler.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ir_scan_scheduler.sv
// ir_scan_scheduler: time-shares one ADC and one adc_lut across the
// front, diagonal-left and diagonal-right IR sensors.
//   clk, reset (async, active-low), enable (scan while high)
//   adc_start/adc_channel -> ADC, adc_done/adc_data <- ADC
//   lut_adc_data -> adc_lut, lut_distance <- adc_lut
//   dist_front/left/right, scan_done, timeout_err -> wall follower
`timescale 1ns/1ps
module ir_scan_scheduler #(
  parameter int         SCAN_PERIOD = 50000,
  parameter int         AVG_LOG2    = 2,
  parameter int         TIMEOUT     = 1000,
  parameter logic [1:0] CH_FRONT    = 2'd0,
  parameter logic [1:0] CH_LEFT     = 2'd1,
  parameter logic [1:0] CH_RIGHT    = 2'd2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  output logic               adc_start,
  output logic [1:0]         adc_channel,
  input  logic               adc_done,
  input  logic signed [15:0] adc_data,
  output logic signed [15:0] lut_adc_data,
  input  logic [6:0]         lut_distance,
  output logic [6:0]         dist_front,
  output logic [6:0]         dist_left,
  output logic [6:0]         dist_right,
  output logic               scan_done,
  output logic               timeout_err
);

  localparam int AW = 16 + AVG_LOG2;
  localparam int SW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int PW = $clog2(SCAN_PERIOD);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int NS = 1 << AVG_LOG2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT,
    LOOKUP,
    STORE,
    NEXT
  } state_t;

  state_t               state;
  logic [1:0]           idx;
  logic [SW-1:0]        scnt;
  logic [TW-1:0]        tcnt;
  logic signed [AW-1:0] acc;
  logic                 pending;
  logic [PW-1:0]        per_cnt;
  logic                 scan_req;

  function automatic logic [1:0] ch_code(
    input logic [1:0] i
  );
    unique case (1'b1)
      i == 2'd1: ch_code = CH_LEFT;
      i == 2'd2: ch_code = CH_RIGHT;
      default:   ch_code = CH_FRONT;
    endcase
  endfunction

  assign scan_req = enable && (per_cnt == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      per_cnt <= '0;
    end else if (!enable) begin
      per_cnt <= '0;
    end else if (per_cnt == PW'(SCAN_PERIOD - 1)) begin
      per_cnt <= '0;
    end else begin
      per_cnt <= per_cnt + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      idx          <= '0;
      scnt         <= '0;
      tcnt         <= '0;
      acc          <= '0;
      pending      <= 1'b0;
      adc_start    <= 1'b0;
      adc_channel  <= CH_FRONT;
      lut_adc_data <= '0;
      dist_front   <= 7'd80;
      dist_left    <= 7'd80;
      dist_right   <= 7'd80;
      scan_done    <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      adc_start <= 1'b0;
      scan_done <= 1'b0;
      if (!enable) begin
        // abandon whatever is in flight; distances keep their values
        state       <= IDLE;
        pending     <= 1'b0;
        timeout_err <= 1'b0;
      end else begin
        // requests that land mid-scan collapse into one pending bit
        if (scan_req && (state != IDLE)) begin
          pending <= 1'b1;
        end
        unique case (state)
          IDLE: begin
            idx  <= '0;
            acc  <= '0;
            scnt <= '0;
            if (scan_req || pending) begin
              pending     <= 1'b0;
              adc_start   <= 1'b1;
              adc_channel <= ch_code(2'd0);
              state       <= START;
            end
          end
          START: begin
            tcnt  <= '0;
            state <= WAIT;
          end
          WAIT: begin
            // a done arriving on the timeout cycle still counts
            if (adc_done) begin
              acc <= acc + AW'(adc_data);
              if (scnt == SW'(NS - 1)) begin
                state <= LOOKUP;
              end else begin
                scnt      <= scnt + SW'(1);
                adc_start <= 1'b1;
                state     <= START;
              end
            end else if (tcnt == TW'(TIMEOUT - 1)) begin
              timeout_err <= 1'b1;
              state       <= NEXT;
            end else begin
              tcnt <= tcnt + TW'(1);
            end
          end
          LOOKUP: begin
            // arithmetic shift gives floor division for negatives
            lut_adc_data <= 16'(acc >>> AVG_LOG2);
            state        <= STORE;
          end
          STORE: begin
            unique case (1'b1)
              idx == 2'd1: dist_left  <= lut_distance;
              idx == 2'd2: dist_right <= lut_distance;
              default:     dist_front <= lut_distance;
            endcase
            state <= NEXT;
          end
          NEXT: begin
            if (idx == 2'd2) begin
              scan_done <= 1'b1;
              state     <= IDLE;
            end else begin
              idx         <= idx + 2'd1;
              acc         <= '0;
              scnt        <= '0;
              adc_start   <= 1'b1;
              adc_channel <= ch_code(idx + 2'd1);
              state       <= START;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ir_scan_scheduler.sv
// tb_ir_scan_scheduler: randomized scoreboard bench for ir_scan_scheduler
// with an ADC responder, a LUT stub and directed enable/reset cases.
`timescale 1ns/1ps
module tb_ir_scan_scheduler;

  localparam int         P      = 60;
  localparam int         AL     = 2;
  localparam int         TO     = 8;
  localparam int         AVGN   = 1 << AL;
  localparam int         NSCANS = 40;
  localparam logic [1:0] CF     = 2'd0;
  localparam logic [1:0] CL     = 2'd1;
  localparam logic [1:0] CR     = 2'd2;

  logic               clk;
  logic               reset;
  logic               enable;
  logic               adc_start;
  logic [1:0]         adc_channel;
  logic               adc_done;
  logic signed [15:0] adc_data;
  logic signed [15:0] lut_adc_data;
  logic [6:0]         lut_distance;
  logic [6:0]         dist_front;
  logic [6:0]         dist_left;
  logic [6:0]         dist_right;
  logic               scan_done;
  logic               timeout_err;
  logic [15:0]        lut_u;

  ir_scan_scheduler #(
    .SCAN_PERIOD(P),
    .AVG_LOG2(AL),
    .TIMEOUT(TO),
    .CH_FRONT(CF),
    .CH_LEFT(CL),
    .CH_RIGHT(CR)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .adc_start(adc_start),
    .adc_channel(adc_channel),
    .adc_done(adc_done),
    .adc_data(adc_data),
    .lut_adc_data(lut_adc_data),
    .lut_distance(lut_distance),
    .dist_front(dist_front),
    .dist_left(dist_left),
    .dist_right(dist_right),
    .scan_done(scan_done),
    .timeout_err(timeout_err)
  );

  // LUT stub: any injective-looking map of the 16-bit code into 10..80
  assign lut_u        = lut_adc_data;
  assign lut_distance = 7'(10 + lut_u % 16'd71);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int lat;
    int val;
    bit respond;
  } conv_t;

  typedef struct {
    int f;
    int l;
    int r;
    bit terr;
  } scan_t;

  conv_t      conv_q[$];
  logic [1:0] exp_ch_q[$];
  scan_t      exp_scan_q[$];
  int         m_dist[3];
  bit         m_terr;
  int         planned;
  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  int         e_cyc   = 0;
  bit         mon_on  = 0;
  int         scans_seen = 0;
  bit         started    = 0;
  int         s_cyc      = 0;
  int         exp_start  = 0;
  scan_t      mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act,
                       input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: expected event did not occur", name);
  endtask

  function automatic int lut_fn(input int avg);
    int u;
    u = avg & 32'hFFFF;
    return 10 + u % 71;
  endfunction

  function automatic int floor_avg(input int s);
    int q;
    q = s / AVGN;
    if ((s % AVGN != 0) && (s < 0)) q = q - 1;
    return q;
  endfunction

  function automatic int pick_val(input int k, input int c, input int s);
    int dl[4];
    dl[0] = -3;
    dl[1] = -2;
    dl[2] = -2;
    dl[3] = -2;
    if (k == 0 && c == 0) return 1000 + 2 * s;
    if (k == 0 && c == 1) return dl[s % 4];
    case ($urandom_range(0, 2))
      0: return int'($urandom_range(0, 16)) - 8;
      1: return int'($urandom_range(0, 65535)) - 32768;
      default:
        if ($urandom_range(0, 1) != 0)
          return 32767 - int'($urandom_range(0, 3));
        else
          return -32768 + int'($urandom_range(0, 3));
    endcase
  endfunction

  task automatic push_conv(input int lat, input int val);
    conv_t cv;
    cv.lat     = lat;
    cv.val     = val;
    cv.respond = 1'b1;
    conv_q.push_back(cv);
  endtask

  // one scan planned ahead: conversions for the responder, expected
  // channel order, and the distances/error the scan must leave behind
  task automatic plan_scan(input int k);
    logic [1:0] codes[3];
    scan_t      e;
    codes[0] = CF;
    codes[1] = CL;
    codes[2] = CR;
    for (int c = 0; c < 3; c++) begin
      int tmo;
      int sum;
      tmo = -1;
      sum = 0;
      if (k == 2 && c == 1) tmo = 0;
      else if (k >= 3 && $urandom_range(0, 5) == 0)
        tmo = int'($urandom_range(0, AVGN - 1));
      for (int s = 0; s < AVGN; s++) begin
        conv_t cv;
        exp_ch_q.push_back(codes[c]);
        cv.respond = (s != tmo);
        cv.lat     = (k == 1) ? TO : int'($urandom_range(1, TO));
        cv.val     = pick_val(k, c, s);
        conv_q.push_back(cv);
        if (!cv.respond) break;
        sum += cv.val;
      end
      if (tmo >= 0) m_terr = 1'b1;
      else m_dist[c] = lut_fn(floor_avg(sum));
    end
    e.f    = m_dist[0];
    e.l    = m_dist[1];
    e.r    = m_dist[2];
    e.terr = m_terr;
    exp_scan_q.push_back(e);
  endtask

  // ADC responder: done lands in WAIT cycle `lat` after the start
  initial begin
    conv_t cv;
    adc_done = 1'b0;
    adc_data = '0;
    forever begin
      @(negedge clk);
      adc_done = 1'b0;
      if (adc_start && conv_q.size() > 0) begin
        cv = conv_q.pop_front();
        if (conv_q.size() == 0 && planned > 0 && planned < NSCANS) begin
          plan_scan(planned);
          planned++;
        end
        if (cv.respond) begin
          repeat (cv.lat) @(negedge clk);
          adc_done = 1'b1;
          adc_data = 16'(cv.val);
        end
      end
    end
  end

  // monitor: channel order, scan start timing, per-scan results
  always @(negedge clk) begin
    if (mon_on && scans_seen < NSCANS) begin
      if (adc_start) begin
        if (exp_ch_q.size() == 0) fail_now("adc_channel_unexpected");
        else check("adc_channel", adc_channel, exp_ch_q.pop_front());
        if (!started) begin
          check("scan_start_cycle", cyc,
                (scans_seen == 0) ? e_cyc + 1 : exp_start);
          s_cyc   = cyc;
          started = 1'b1;
        end
      end
      if (scan_done) begin
        int r0;
        if (exp_scan_q.size() == 0) begin
          fail_now("scan_done_unexpected");
        end else begin
          mon_e = exp_scan_q.pop_front();
          check("dist_front", dist_front, mon_e.f);
          check("dist_left", dist_left, mon_e.l);
          check("dist_right", dist_right, mon_e.r);
          check("timeout_err", timeout_err, mon_e.terr);
        end
        // requests fire every P cycles from e_cyc; any in [s_cyc, now]
        // is held and launches the cycle after IDLE is re-entered
        r0 = e_cyc + ((s_cyc - e_cyc + P - 1) / P) * P;
        exp_start = (r0 <= cyc) ? cyc + 1 : r0 + 1;
        started   = 1'b0;
        scans_seen++;
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_adc_start"}, adc_start, 0);
    check({tag, "_adc_channel"}, adc_channel, CF);
    check({tag, "_lut_adc_data"}, lut_adc_data, 0);
    check({tag, "_dist_front"}, dist_front, 80);
    check({tag, "_dist_left"}, dist_left, 80);
    check({tag, "_dist_right"}, dist_right, 80);
    check({tag, "_scan_done"}, scan_done, 0);
    check({tag, "_timeout_err"}, timeout_err, 0);
  endtask

  initial begin
    int   found;
    int   seen_sd;
    int   seen_st;
    int   c0;
    logic [6:0] d_l;
    logic [6:0] d_r;
    reset   = 1'b0;
    enable  = 1'b0;
    planned = 0;
    m_dist[0] = 80;
    m_dist[1] = 80;
    m_dist[2] = 80;
    m_terr    = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("in_reset");
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_vals("post_reset");

    plan_scan(0);
    planned = 1;
    mon_on  = 1'b1;
    e_cyc   = cyc;
    enable  = 1'b1;
    for (int i = 0; i < 40000 && scans_seen < NSCANS; i++)
      @(negedge clk);
    if (scans_seen < NSCANS) fail_now("random_phase_budget");
    mon_on = 1'b0;

    @(negedge clk);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    conv_q.delete();
    check("terr_clear_on_disable", timeout_err, 0);
    d_l = dist_left;
    d_r = dist_right;
    for (int i = 0; i < AVGN; i++) push_conv(2, 500);
    push_conv(5, 100);
    enable = 1'b1;
    found  = 0;
    for (int i = 0; i < 300 && found == 0; i++) begin
      @(negedge clk);
      if (adc_start && adc_channel == CL) found = 1;
    end
    if (found == 0) fail_now("left_start_wait");
    repeat (2) @(negedge clk);
    enable  = 1'b0;
    seen_sd = 0;
    seen_st = 0;
    repeat (12) begin
      @(negedge clk);
      if (scan_done) seen_sd++;
      if (adc_start) seen_st++;
    end
    check("no_scan_done_after_drop", seen_sd, 0);
    check("no_start_while_disabled", seen_st, 0);
    check("front_after_drop", dist_front, lut_fn(500));
    check("left_hold_after_drop", dist_left, d_l);
    check("right_hold_after_drop", dist_right, d_r);
    check("terr_after_drop", timeout_err, 0);

    conv_q.delete();
    for (int i = 0; i < AVGN; i++) push_conv(1, 7);
    @(negedge clk);
    enable = 1'b1;
    c0     = cyc;
    @(negedge clk);
    check("restart_cycle", cyc, c0 + 1);
    check("restart_start", adc_start, 1);
    check("restart_channel", adc_channel, CF);
    repeat (7) @(negedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_reset_vals("async_reset");
    @(negedge clk);
    enable = 1'b0;
    reset  = 1'b1;
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
